// File: rtl/pcie_resp_sched_pkg.sv
// Shared AMI types: app count, scheduler constants and the scheduler state encoding.
package AMITypes;

    localparam int AMI_NUM_APPS              = 4;
    localparam int AMI_APP_BITS              = 2;
    localparam int PCIE_SCHED_WEIGHT_W       = 4;
    localparam int PCIE_SCHED_TIMEOUT_CYCLES = 1023;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } SchedState_t;

endpackage

// File: rtl/pcie_resp_sched_rr_pick.sv
// rr_pick: combinational circular priority picker; grants the first set req bit at or after ptr.
module rr_pick
    import AMITypes::*;
#(
    parameter int N     = AMI_NUM_APPS,
    parameter int PTR_W = AMI_APP_BITS
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + off) % N)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcie_resp_sched.sv
// Packet-atomic weighted round-robin scheduler for the unified PCIe response queue.
// Optional per-app packet and abort statistics are built when PCIE_SCHED_STATS_EN is defined.
module pcie_resp_sched
    import AMITypes::*;
#(
    parameter int N              = AMI_NUM_APPS,
    parameter int WEIGHT_W       = PCIE_SCHED_WEIGHT_W,
    parameter int TIMEOUT_W      = 10,
    parameter int TIMEOUT_CYCLES = PCIE_SCHED_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          app_enable,
    input  logic [N-1:0]          req_valid,
    input  logic [N-1:0]          req_last,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  out_ready,
    output logic [N-1:0]          sel,
    output logic [N-1:0]          req_deq,
    output logic                  out_enq,
    output logic                  abort,
    output logic [N-1:0]          abort_app
`ifdef PCIE_SCHED_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [N*32-1:0]       pkt_count,
    output logic [15:0]           abort_count
`endif
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    SchedState_t          state;
    logic [N-1:0]         owner;
    logic [PTR_W-1:0]     owner_idx;
    logic [PTR_W-1:0]     rr_ptr;
    logic [WEIGHT_W-1:0]  quota;
    logic [WEIGHT_W-1:0]  pkt_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 mid_pkt;

    logic [N-1:0]         elig;
    logic [N-1:0]         grant;
    logic [PTR_W-1:0]     grant_idx;
    logic [WEIGHT_W-1:0]  grant_weight;
    logic [PTR_W-1:0]     next_ptr;
    logic [WEIGHT_W-1:0]  pkt_next;
    logic                 own_valid;
    logic                 own_last;
    logic                 own_en;
    logic                 xfer;
    logic                 wd_expired;
    logic                 abort_now;
    logic                 leave;

    assign elig = req_valid & app_enable;

    rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx    = '0;
        grant_weight = '0;
        for (int j = 0; j < N; j++) begin
            if (grant[j]) begin
                grant_idx    = PTR_W'(j);
                grant_weight = weight[j*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    // owner is all-zero while IDLE, so every owner-qualified term is inactive there.
    assign own_valid  = |(req_valid & owner);
    assign own_last   = |(req_last & owner);
    assign own_en     = |(app_enable & owner);
    assign xfer       = own_valid & out_ready & own_en;
    assign pkt_next   = pkt_cnt + WEIGHT_W'(1);
    assign next_ptr   = (owner_idx == PTR_W'(N - 1)) ? '0 : owner_idx + PTR_W'(1);
    assign wd_expired = mid_pkt && own_en && !own_valid && (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));
    assign abort_now  = rst_n && (state == ACTIVE) && mid_pkt && (!own_en || wd_expired);
    assign leave      = (state == ACTIVE) &&
                        (!own_en || wd_expired || (!mid_pkt && !own_valid) ||
                         (xfer && own_last && (pkt_next == quota)));

    assign sel       = owner;
    assign req_deq   = xfer ? owner : '0;
    assign out_enq   = xfer;
    assign abort     = abort_now;
    assign abort_app = abort_now ? owner : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            owner_idx <= '0;
            rr_ptr    <= '0;
            quota     <= '0;
            pkt_cnt   <= '0;
            wd_cnt    <= '0;
            mid_pkt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        state     <= ACTIVE;
                        owner     <= grant;
                        owner_idx <= grant_idx;
                        quota     <= (grant_weight == '0) ? WEIGHT_W'(1) : grant_weight;
                        pkt_cnt   <= '0;
                        wd_cnt    <= '0;
                        mid_pkt   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (leave) begin
                        state   <= IDLE;
                        owner   <= '0;
                        rr_ptr  <= next_ptr;
                        pkt_cnt <= '0;
                        wd_cnt  <= '0;
                        mid_pkt <= 1'b0;
                    end else if (xfer) begin
                        wd_cnt  <= '0;
                        mid_pkt <= !own_last;
                        if (own_last) begin
                            pkt_cnt <= pkt_next;
                        end
                    end else if (mid_pkt && !own_valid) begin
                        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= '0;
                end
            endcase
        end
    end

`ifdef PCIE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            pkt_count   <= '0;
            abort_count <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (xfer && own_last && owner[i]) begin
                    pkt_count[i*32 +: 32] <= pkt_count[i*32 +: 32] + 32'd1;
                end
            end
            if (abort_now && (abort_count != 16'hFFFF)) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcie_resp_sched.sv
// Directed self-checking bench for pcie_resp_sched (N=4, weight width 4, timeout 1023).
module tb_pcie_resp_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  app_enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [15:0] weight;
    logic        out_ready;
    logic [3:0]  sel;
    logic [3:0]  req_deq;
    logic        out_enq;
    logic        abort;
    logic [3:0]  abort_app;
`ifdef PCIE_SCHED_STATS_EN
    logic         stats_clr;
    logic [127:0] pkt_count;
    logic [15:0]  abort_count;
`endif

    int checks;
    int errors;

    pcie_resp_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .app_enable (app_enable),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .weight     (weight),
        .out_ready  (out_ready),
        .sel        (sel),
        .req_deq    (req_deq),
        .out_enq    (out_enq),
        .abort      (abort),
        .abort_app  (abort_app)
`ifdef PCIE_SCHED_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .pkt_count   (pkt_count),
        .abort_count (abort_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        app_enable = 4'b1111;
        req_valid  = 4'b0000;
        req_last   = 4'b0000;
        weight     = 16'h1111;
        out_ready  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (sel !== 4'b0000) begin
            $display("[TB] FAIL reset_sel: got %b expected 0000", sel); errors++;
        end
        checks++;
        if (req_deq !== 4'b0000) begin
            $display("[TB] FAIL reset_req_deq: got %b expected 0000", req_deq); errors++;
        end
        checks++;
        if (out_enq !== 1'b0 || abort !== 1'b0 || abort_app !== 4'b0000) begin
            $display("[TB] FAIL reset_enq_abort: got enq=%b abort=%b app=%b expected 0 0 0000",
                     out_enq, abort, abort_app); errors++;
        end
    endtask

    task automatic test_single_packet();
        logic [3:0] exp_sel [7];
        logic [3:0] rv      [7];
        logic [3:0] rl      [7];
        exp_sel = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
        rv      = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1001, 4'b1001};
        rl      = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1001, 4'b1001};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req_valid = rv[c];
            req_last  = rl[c];
            #1;
            checks++;
            if (sel !== exp_sel[c] || req_deq !== exp_sel[c] || out_enq !== (|exp_sel[c])) begin
                $display("[TB] FAIL single_c%0d: got sel=%b deq=%b enq=%b expected sel=deq=%b",
                         c, sel, req_deq, out_enq, exp_sel[c]); errors++;
            end
        end
    endtask

    task automatic test_weighting();
        logic [3:0] exp_sel [12];
        exp_sel = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                    4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        do_reset();
        weight = 16'h1113;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = 4'b0011;
            req_last  = 4'b0011;
            #1;
            checks++;
            if (sel !== exp_sel[c] || req_deq !== exp_sel[c]) begin
                $display("[TB] FAIL weight_c%0d: got sel=%b deq=%b expected %b",
                         c, sel, req_deq, exp_sel[c]); errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_sel [7];
        logic [3:0] rv      [7];
        logic [3:0] rl      [7];
        logic       exp_enq [7];
        exp_sel = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        rv      = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        rl      = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        exp_enq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        weight = 16'h1113;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req_valid = rv[c];
            req_last  = rl[c];
            #1;
            checks++;
            if (sel !== exp_sel[c] || out_enq !== exp_enq[c]) begin
                $display("[TB] FAIL b2b_c%0d: got sel=%b enq=%b expected sel=%b enq=%b",
                         c, sel, out_enq, exp_sel[c], exp_enq[c]); errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic saw_abort;
        logic saw_enq;
        saw_abort = 1'b0;
        saw_enq   = 1'b0;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        @(negedge clk);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            if (abort !== 1'b0) saw_abort = 1'b1;
            if (out_enq !== 1'b0 || sel !== 4'b0001) saw_enq = 1'b1;
        end
        checks++;
        if (saw_abort) begin
            $display("[TB] FAIL bp_no_abort: got abort during stall expected none"); errors++;
        end
        checks++;
        if (saw_enq) begin
            $display("[TB] FAIL bp_hold: got enq or sel change during stall expected sel=0001 enq=0"); errors++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        req_last  = 4'b0001;
        #1;
        checks++;
        if (out_enq !== 1'b1 || req_deq !== 4'b0001) begin
            $display("[TB] FAIL bp_resume: got enq=%b deq=%b expected 1 0001", out_enq, req_deq); errors++;
        end
    endtask

    task automatic test_starve();
        logic early;
        early = 1'b0;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        @(negedge clk);
        for (int k = 0; k < 1023; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 4'b0100;
            #1;
            if (abort !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            $display("[TB] FAIL starve_early: got abort before 1023 cycles expected none"); errors++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (abort !== 1'b1 || abort_app !== 4'b0010 || out_enq !== 1'b0) begin
            $display("[TB] FAIL starve_abort: got abort=%b app=%b enq=%b expected 1 0010 0",
                     abort, abort_app, out_enq); errors++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel !== 4'b0000 || abort !== 1'b0) begin
            $display("[TB] FAIL starve_idle: got sel=%b abort=%b expected 0000 0", sel, abort); errors++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel !== 4'b0100) begin
            $display("[TB] FAIL starve_next: got sel=%b expected 0100", sel); errors++;
        end
    endtask

    task automatic test_disable();
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req_deq !== 4'b1000) begin
            $display("[TB] FAIL dis_beat2: got deq=%b expected 1000", req_deq); errors++;
        end
        @(negedge clk);
        app_enable = 4'b0111;
        #1;
        checks++;
        if (abort !== 1'b1 || abort_app !== 4'b1000 || out_enq !== 1'b0 || req_deq !== 4'b0000) begin
            $display("[TB] FAIL dis_abort: got abort=%b app=%b enq=%b deq=%b expected 1 1000 0 0000",
                     abort, abort_app, out_enq, req_deq); errors++;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (sel !== 4'b0000 || abort !== 1'b0) begin
                $display("[TB] FAIL dis_skip_c%0d: got sel=%b abort=%b expected 0000 0", c, sel, abort); errors++;
            end
        end
        @(negedge clk);
        req_valid = 4'b1001;
        @(negedge clk);
        #1;
        checks++;
        if (sel !== 4'b0001) begin
            $display("[TB] FAIL dis_other: got sel=%b expected 0001", sel); errors++;
        end
        app_enable = 4'b1111;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0101;
        #1;
        checks++;
        if (sel !== 4'b0000 || out_enq !== 1'b0 || abort !== 1'b0) begin
            $display("[TB] FAIL rstmid_clear: got sel=%b enq=%b abort=%b expected 0000 0 0",
                     sel, out_enq, abort); errors++;
        end
`ifdef PCIE_SCHED_STATS_EN
        checks++;
        if (pkt_count !== 128'd0) begin
            $display("[TB] FAIL rstmid_stats: got %h expected 0", pkt_count); errors++;
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if (sel !== 4'b0001) begin
            $display("[TB] FAIL rstmid_restart: got sel=%b expected 0001", sel); errors++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        app_enable = 4'b1111;
        req_valid  = 4'b0000;
        req_last   = 4'b0000;
        weight     = 16'h1111;
        out_ready  = 1'b1;
`ifdef PCIE_SCHED_STATS_EN
        stats_clr  = 1'b0;
`endif
        test_reset();
        test_single_packet();
        test_weighting();
        test_back_to_back();
        test_backpressure();
        test_starve();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
